// File: rtl/cpu_pkg.sv
// Shared definitions for the memory bus controller slice.
// - DEF_ADDR_W / DEF_DATA_W : default requester and RAM port widths
// - mbc_state_t             : controller state encoding
// - port_t                  : requester ids (fetch / data)
package cpu_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_ERROR   = 2'd3
    } mbc_state_t;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_t;

endpackage

// File: rtl/mem_arb2.sv
// Two-input round-robin arbiter.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_a, req_b      requests (a = fetch, b = data)
//   advance           1 when the grant is actually taken; updates last_grant
//   grant_a, grant_b  one-hot (or zero) grant, combinational from requests
// After reset last_grant is FETCH, so the data port wins the first tie.
module mem_arb2
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic advance,
    output logic grant_a,
    output logic grant_b
);

    port_t last_grant_reg;

    // On a tie, the port that did not win last time gets the grant.
    always_comb begin
        grant_a = req_a & (~req_b | (last_grant_reg == PORT_DATA));
        grant_b = req_b & (~req_a | (last_grant_reg == PORT_FETCH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= PORT_FETCH;
        end else if (advance) begin
            if (grant_a) begin
                last_grant_reg <= PORT_FETCH;
            end else if (grant_b) begin
                last_grant_reg <= PORT_DATA;
            end
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: arbitrates instruction fetch and load/store data
// requests onto a single handshaked RAM port.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   if_req/if_addr                   fetch request (read only)
//   if_done/if_rdata                 fetch completion pulse and data
//   d_req/d_we/d_addr/d_wdata        load/store request
//   d_done/d_rdata                   data completion pulse and load data
//   err                              valid with a done pulse: range or timeout
//   busy                             controller not idle
//   mem_en/read/write/address/wdata  RAM command pins (all registered)
//   mem_rdata/mem_ready              RAM response
// Each access runs IDLE -> ACCESS -> RELEASE -> IDLE; RELEASE keeps mem_en
// low for one cycle so the RAM's wait counter re-arms between accesses.
// Out-of-range addresses go IDLE -> ERROR -> IDLE without touching the RAM.
module mem_bus_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_DEPTH = 128,
    parameter int TIMEOUT   = 15
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int WDOG_W = $clog2(TIMEOUT + 1);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT);

    mbc_state_t        state_reg;
    port_t             port_reg;
    logic [WDOG_W-1:0] wdog_reg;
    logic [WDOG_W-1:0] wdog_next;
    logic              if_done_reg;
    logic              d_done_reg;
    logic              err_reg;
    logic              busy_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;
    logic              mem_en_reg;
    logic              mem_read_reg;
    logic              mem_write_reg;
    logic [ADDR_W-1:0] mem_address_reg;
    logic [DATA_W-1:0] mem_wdata_reg;

    logic              grant_fetch;
    logic              grant_data;
    logic              arb_advance;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic              sel_oor;

    // Grants only matter while IDLE; requests seen in other states are ignored.
    assign arb_advance = (state_reg == ST_IDLE);

    mem_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_a   (if_req),
        .req_b   (d_req),
        .advance (arb_advance),
        .grant_a (grant_fetch),
        .grant_b (grant_data)
    );

    // Request mux for the winning port; fetches are always reads.
    assign sel_addr  = grant_data ? d_addr : if_addr;
    assign sel_we    = grant_data & d_we;
    assign sel_oor   = (32'(sel_addr) >= 32'(MEM_DEPTH));
    assign wdog_next = wdog_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            port_reg        <= PORT_FETCH;
            wdog_reg        <= '0;
            if_done_reg     <= 1'b0;
            d_done_reg      <= 1'b0;
            err_reg         <= 1'b0;
            busy_reg        <= 1'b0;
            if_rdata_reg    <= '0;
            d_rdata_reg     <= '0;
            mem_en_reg      <= 1'b0;
            mem_read_reg    <= 1'b0;
            mem_write_reg   <= 1'b0;
            mem_address_reg <= '0;
            mem_wdata_reg   <= '0;
        end else begin
            // Done and err are single-cycle pulses.
            if_done_reg <= 1'b0;
            d_done_reg  <= 1'b0;
            err_reg     <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (grant_fetch || grant_data) begin
                        port_reg        <= grant_data ? PORT_DATA : PORT_FETCH;
                        mem_address_reg <= sel_addr;
                        mem_wdata_reg   <= grant_data ? d_wdata : '0;
                        mem_write_reg   <= sel_we;
                        busy_reg        <= 1'b1;
                        if (sel_oor) begin
                            state_reg <= ST_ERROR;
                        end else begin
                            state_reg    <= ST_ACCESS;
                            mem_en_reg   <= 1'b1;
                            mem_read_reg <= ~sel_we;
                            wdog_reg     <= '0;
                        end
                    end
                end

                ST_ACCESS: begin
                    if (mem_ready) begin
                        if (port_reg == PORT_DATA) begin
                            d_done_reg <= 1'b1;
                            // Stores leave the load data register untouched.
                            if (!mem_write_reg) begin
                                d_rdata_reg <= mem_rdata;
                            end
                        end else begin
                            if_done_reg  <= 1'b1;
                            if_rdata_reg <= mem_rdata;
                        end
                        mem_en_reg    <= 1'b0;
                        mem_read_reg  <= 1'b0;
                        mem_write_reg <= 1'b0;
                        state_reg     <= ST_RELEASE;
                    end else if (wdog_next == WDOG_LIMIT) begin
                        // RAM never answered: abort with an error, data unchanged.
                        if (port_reg == PORT_DATA) begin
                            d_done_reg <= 1'b1;
                        end else begin
                            if_done_reg <= 1'b1;
                        end
                        err_reg       <= 1'b1;
                        mem_en_reg    <= 1'b0;
                        mem_read_reg  <= 1'b0;
                        mem_write_reg <= 1'b0;
                        state_reg     <= ST_RELEASE;
                    end else begin
                        wdog_reg <= wdog_next;
                    end
                end

                ST_RELEASE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end

                ST_ERROR: begin
                    if (port_reg == PORT_DATA) begin
                        d_done_reg <= 1'b1;
                    end else begin
                        if_done_reg <= 1'b1;
                    end
                    err_reg       <= 1'b1;
                    mem_write_reg <= 1'b0;
                    state_reg     <= ST_IDLE;
                    busy_reg      <= 1'b0;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign if_done     = if_done_reg;
    assign if_rdata    = if_rdata_reg;
    assign d_done      = d_done_reg;
    assign d_rdata     = d_rdata_reg;
    assign err         = err_reg;
    assign busy        = busy_reg;
    assign mem_en      = mem_en_reg;
    assign mem_read    = mem_read_reg;
    assign mem_write   = mem_write_reg;
    assign mem_address = mem_address_reg;
    assign mem_wdata   = mem_wdata_reg;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl paired with a one-wait 128x8 RAM model.
module tb_mem_bus_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       if_req = 1'b0;
    logic [7:0] if_addr = 8'h00;
    logic       if_done;
    logic [7:0] if_rdata;
    logic       d_req = 1'b0;
    logic       d_we = 1'b0;
    logic [7:0] d_addr = 8'h00;
    logic [7:0] d_wdata = 8'h00;
    logic       d_done;
    logic [7:0] d_rdata;
    logic       err;
    logic       busy;
    logic       mem_en;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_address;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_ready = 1'b0;

    always #5 clk = ~clk;

    mem_bus_ctrl #(
        .ADDR_W(8), .DATA_W(8), .MEM_DEPTH(128), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .err(err), .busy(busy),
        .mem_en(mem_en), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    // RAM model: one wait cycle after en is seen, ready stays high while en
    // is held, and clears once en drops. stall holds ready low forever.
    logic [7:0] ram [0:127];
    logic       ram_cnt = 1'b0;
    logic       preload_done = 1'b0;
    logic       stall = 1'b0;

    always @(posedge clk) begin
        if (!preload_done) begin
            for (int i = 0; i < 128; i++) ram[i] <= 8'h00;
            ram[1] <= 8'h05;
            preload_done <= 1'b1;
        end else if (!mem_en) begin
            ram_cnt   <= 1'b0;
            mem_ready <= 1'b0;
        end else if (ram_cnt == 1'b0) begin
            ram_cnt <= 1'b1;
        end else if (!stall) begin
            mem_ready <= 1'b1;
            if (mem_write) ram[mem_address[6:0]] <= mem_wdata;
            else           mem_rdata <= ram[mem_address[6:0]];
        end
    end

    // Reference model: memory contents, last grant, rdata registers.
    logic [7:0] ref_mem [0:127];
    bit         lg_data;
    logic [7:0] exp_if_rdata;
    logic [7:0] exp_d_rdata;
    int         n_checks = 0;
    int         n_errors = 0;
    bit         seen_en;

    typedef struct {
        bit         is_d;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        bit         exp_err;
        int         exp_cyc;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        if_req = 1'b0;
        d_req = 1'b0;
        stall = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        lg_data = 1'b0;
        exp_if_rdata = 8'h00;
        exp_d_rdata = 8'h00;
    endtask

    // Model bookkeeping for one completed grant.
    task automatic model_commit(input bit is_d, input bit we, input logic [7:0] addr,
                                input logic [7:0] wdata, input bit is_err);
        lg_data = is_d;
        if (!is_err && we) ref_mem[addr[6:0]] = wdata;
        if (!is_err && !we) begin
            if (is_d) exp_d_rdata = ref_mem[addr[6:0]];
            else      exp_if_rdata = ref_mem[addr[6:0]];
        end
    endtask

    // Single-port transaction; called at a negedge with the controller idle.
    task automatic do_txn(input string name, input bit is_d, input bit we,
                          input logic [7:0] addr, input logic [7:0] wdata,
                          input logic [7:0] exp_rdata, input bit exp_err, input int exp_cyc);
        bit gf, gd, oor;
        int cyc;
        logic [7:0] want_rdata;
        oor = (addr >= 8'd128);
        want_rdata = (exp_err || we) ? (is_d ? exp_d_rdata : exp_if_rdata) : exp_rdata;
        seen_en = 1'b0;
        gf = 1'b0; gd = 1'b0; cyc = 0;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        while (!(gf || gd) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            seen_en |= mem_en;
            if (cyc == 1 && !oor) begin
                check({name, "_en"}, mem_en, 1);
                check({name, "_addr"}, mem_address, addr);
                check({name, "_rdwr"}, {mem_read, mem_write}, {~we, we});
                if (we) check({name, "_wdata"}, mem_wdata, wdata);
            end
            gf = if_done; gd = d_done;
        end
        if_req = 1'b0; d_req = 1'b0;
        check({name, "_port"}, {gf, gd}, is_d ? 2'b01 : 2'b10);
        check({name, "_cyc"}, cyc, exp_cyc);
        check({name, "_err"}, err, exp_err);
        check({name, "_rdata"}, is_d ? d_rdata : if_rdata, want_rdata);
        if (oor) begin
            check({name, "_noen"}, seen_en, 0);
            check({name, "_idle"}, busy, 0);
        end else begin
            check({name, "_release"}, {busy, mem_en}, 2'b10);
            @(negedge clk);
            check({name, "_idle"}, busy, 0);
        end
        model_commit(is_d, we, addr, wdata, exp_err);
        $display("txn %s: port=%s we=%0d addr=%h rdata=%h err=%0d cyc=%0d",
                 name, is_d ? "D" : "F", we, addr, is_d ? d_rdata : if_rdata, err, cyc);
        @(negedge clk);
    endtask

    // Both ports request together; completion order follows round robin.
    task automatic do_pair(input string name, input logic [7:0] f_addr, input bit dwe,
                           input logic [7:0] daddr, input logic [7:0] dwdata);
        bit first_d, exp_d, gf, gd, e_err, e_we;
        int cyc;
        logic [7:0] e_addr, want;
        first_d = ~lg_data;
        if_req = 1'b1; if_addr = f_addr;
        d_req = 1'b1; d_we = dwe; d_addr = daddr; d_wdata = dwdata;
        for (int k = 0; k < 2; k++) begin
            exp_d = (k == 0) ? first_d : ~first_d;
            e_addr = exp_d ? daddr : f_addr;
            e_we = exp_d & dwe;
            e_err = (e_addr >= 8'd128);
            want = (e_err || e_we) ? (exp_d ? exp_d_rdata : exp_if_rdata) : ref_mem[e_addr[6:0]];
            gf = 1'b0; gd = 1'b0; cyc = 0;
            while (!(gf || gd) && cyc < 40) begin
                @(negedge clk);
                cyc++;
                gf = if_done; gd = d_done;
            end
            if (gd) d_req = 1'b0;
            if (gf) if_req = 1'b0;
            check($sformatf("%s_%0d_port", name, k), {gf, gd}, exp_d ? 2'b01 : 2'b10);
            check($sformatf("%s_%0d_err", name, k), err, e_err);
            check($sformatf("%s_%0d_rdata", name, k), exp_d ? d_rdata : if_rdata, want);
            model_commit(exp_d, e_we, e_addr, dwdata, e_err);
            $display("txn %s.%0d: port=%s addr=%h rdata=%h err=%0d",
                     name, k, exp_d ? "D" : "F", e_addr, exp_d ? d_rdata : if_rdata, err);
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bit gf, gd, rd_d, rd_we;
        int cyc, t_first, t_now;
        logic [7:0] ra, rf, rw;

        for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
        ref_mem[1] = 8'h05;

        vecs[0] = '{0, 0, 8'h01, 8'h00, 8'h05, 0, 4};
        vecs[1] = '{1, 1, 8'h10, 8'hA5, 8'h00, 0, 4};
        vecs[2] = '{1, 0, 8'h10, 8'h00, 8'hA5, 0, 4};
        vecs[3] = '{1, 0, 8'h80, 8'h00, 8'h00, 1, 2};
        vecs[4] = '{0, 0, 8'hFF, 8'h00, 8'h00, 1, 2};
        vecs[5] = '{1, 1, 8'h7F, 8'h3C, 8'h00, 0, 4};
        vecs[6] = '{0, 0, 8'h7F, 8'h00, 8'h3C, 0, 4};
        vecs[7] = '{1, 0, 8'h00, 8'h00, 8'h00, 0, 4};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ctrl", {if_done, d_done, err, busy, mem_en, mem_read, mem_write}, 0);
        check("rst_bus", {mem_address, mem_wdata, if_rdata, d_rdata}, 0);
        do_reset();

        // Directed table
        for (int i = 0; i < 8; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].is_d, vecs[i].we, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_cyc);
        end

        // Back-to-back store then load on the data port, req held between
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 8'h5A;
        t_first = 0; t_now = 0; gd = 1'b0;
        for (int c = 1; c <= 40 && !gd; c++) begin
            @(negedge clk);
            gd = d_done; t_first = c;
        end
        check("b2b_done1", gd, 1);
        d_we = 1'b0;
        gd = 1'b0;
        for (int c = 1; c <= 40 && !gd; c++) begin
            @(negedge clk);
            gd = d_done; t_now = c;
        end
        d_req = 1'b0;
        check("b2b_done2", gd, 1);
        check("b2b_gap", t_now, 5);
        check("b2b_rdata", d_rdata, 8'h5A);
        model_commit(1, 1, 8'h20, 8'h5A, 0);
        model_commit(1, 0, 8'h20, 8'h00, 0);
        $display("txn b2b: store/load 20 gap=%0d rdata=%h", t_now, d_rdata);
        repeat (3) @(negedge clk);

        // Tie after reset: held requests alternate D, F, D, F
        do_reset();
        if_req = 1'b1; if_addr = 8'h01;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
        for (int k = 0; k < 4; k++) begin
            gf = 1'b0; gd = 1'b0; cyc = 0;
            while (!(gf || gd) && cyc < 20) begin
                @(negedge clk);
                cyc++;
                gf = if_done; gd = d_done;
            end
            if (k == 3) begin if_req = 1'b0; d_req = 1'b0; end
            check($sformatf("tie%0d_port", k), {gf, gd}, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k % 2 == 0) check($sformatf("tie%0d_rdata", k), d_rdata, ref_mem[8'h10]);
            else            check($sformatf("tie%0d_rdata", k), if_rdata, ref_mem[1]);
            if (k > 0) check($sformatf("tie%0d_gap", k), cyc, 5);
            $display("txn tie%0d: port=%s cyc=%0d", k, gd ? "D" : "F", cyc);
            model_commit(k % 2 == 0, 0, (k % 2 == 0) ? 8'h10 : 8'h01, 8'h00, 0);
        end
        repeat (3) @(negedge clk);

        // Watchdog: RAM never ready, 15 ACCESS cycles then RELEASE
        stall = 1'b1;
        do_txn("timeout", 0, 0, 8'h01, 8'h00, 8'h00, 1, 16);
        stall = 1'b0;

        // Reset in the middle of an access
        if_req = 1'b1; if_addr = 8'h01;
        repeat (2) @(negedge clk);
        check("midrst_pre_en", mem_en, 1);
        rst_n = 1'b0;
        if_req = 1'b0;
        #1;
        check("midrst_en", mem_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", {if_done, d_done}, 0);
        $display("txn midrst: mem_en=%0d busy=%0d", mem_en, busy);
        do_reset();
        do_txn("post_rst", 0, 0, 8'h01, 8'h00, ref_mem[1], 0, 4);

        // Randomized traffic against the reference model
        for (int r = 0; r < 40; r++) begin
            ra = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 15));
            rf = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 15));
            rw = 8'($urandom);
            rd_we = 1'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                do_pair($sformatf("rnd%0d", r), rf, rd_we, ra, rw);
            end else begin
                rd_d = 1'($urandom);
                if (!rd_d) rd_we = 1'b0;
                do_txn($sformatf("rnd%0d", r), rd_d, rd_we, ra, rw, ref_mem[ra[6:0]],
                       ra >= 8'd128, (ra >= 8'd128) ? 2 : 4);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
